// File: rtl/cpu6502_pkg.sv
// Shared 6502 core constants.
// ADH source select codes and fixed page values.
package cpu6502_pkg;

  localparam logic [2:0] ADH_DATA = 3'd0;
  localparam logic [2:0] ADH_ALU  = 3'd1;
  localparam logic [2:0] ADH_PCHS = 3'd2;
  localparam logic [2:0] ADH_ZERO = 3'd3;
  localparam logic [2:0] ADH_ONE  = 3'd4;
  localparam logic [2:0] ADH_FF   = 3'd5;

  localparam logic [7:0] ADH_CONST_ZERO = 8'h00;
  localparam logic [7:0] ADH_CONST_ONE  = 8'h01;
  localparam logic [7:0] ADH_CONST_FF   = 8'hFF;

endpackage

// File: rtl/adh_source_mux.sv
// ADH source selector.
// Drives the PCHS-side and SB-side ADH views.
module adh_source_mux
  import cpu6502_pkg::*;
(
  input  logic [2:0] adh_sel,
  input  logic [7:0] data_i,
  input  logic [7:0] alu,
  input  logic [7:0] pchs,
  output logic [7:0] adh_pchs,
  output logic [7:0] adh_sb
);

  // pchs is never routed to adh_pchs: pchs is derived from it.
  always_comb begin
    adh_pchs = ADH_CONST_ZERO;
    adh_sb   = ADH_CONST_ZERO;
    case (adh_sel)
      ADH_DATA: begin
        adh_pchs = data_i;
        adh_sb   = data_i;
      end
      ADH_ALU: begin
        adh_pchs = alu;
        adh_sb   = alu;
      end
      ADH_PCHS: begin
        adh_pchs = ADH_CONST_ZERO;
        adh_sb   = pchs;
      end
      ADH_ZERO: begin
        adh_pchs = ADH_CONST_ZERO;
        adh_sb   = ADH_CONST_ZERO;
      end
      ADH_ONE: begin
        adh_pchs = ADH_CONST_ONE;
        adh_sb   = ADH_CONST_ONE;
      end
      ADH_FF: begin
        adh_pchs = ADH_CONST_FF;
        adh_sb   = ADH_CONST_FF;
      end
      default: begin
        adh_pchs = ADH_CONST_ZERO;
        adh_sb   = ADH_CONST_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/adh_bus_unit.sv
// ADH bus steering and address-bus-high register.
// abh drives address[15:8].
module adh_bus_unit
  import cpu6502_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] adh_sel,
  input  logic       load_abh,
  input  logic [7:0] data_i,
  input  logic [7:0] alu,
  input  logic [7:0] pchs,
  output logic [7:0] adh_pchs,
  output logic [7:0] adh_sb,
  output logic [7:0] adh_abh,
  output logic [7:0] abh
);

  adh_source_mux u_mux (
    .adh_sel  (adh_sel),
    .data_i   (data_i),
    .alu      (alu),
    .pchs     (pchs),
    .adh_pchs (adh_pchs),
    .adh_sb   (adh_sb)
  );

  assign adh_abh = (adh_sel == ADH_PCHS) ? pchs : adh_sb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      abh <= ADH_CONST_ZERO;
    else if (load_abh)
      abh <= adh_abh;
  end

endmodule

// File: tb/tb_adh_bus_unit.sv
// Directed self-checking bench for adh_bus_unit.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_adh_bus_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] adh_sel;
  logic       load_abh;
  logic [7:0] data_i;
  logic [7:0] alu;
  logic [7:0] pchs;
  logic [7:0] adh_pchs;
  logic [7:0] adh_sb;
  logic [7:0] adh_abh;
  logic [7:0] abh;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adh_bus_unit dut (
    .clk      (clk),
    .reset    (reset),
    .adh_sel  (adh_sel),
    .load_abh (load_abh),
    .data_i   (data_i),
    .alu      (alu),
    .pchs     (pchs),
    .adh_pchs (adh_pchs),
    .adh_sb   (adh_sb),
    .adh_abh  (adh_abh),
    .abh      (abh)
  );

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_mux(input string tag,
                           input logic [7:0] e_pchs,
                           input logic [7:0] e_sb,
                           input logic [7:0] e_abh);
    check({tag, ".adh_pchs"}, adh_pchs, e_pchs);
    check({tag, ".adh_sb"}, adh_sb, e_sb);
    check({tag, ".adh_abh"}, adh_abh, e_abh);
  endtask

  initial begin
    reset    = 1'b0;
    load_abh = 1'b1;
    adh_sel  = 3'd0;
    data_i   = 8'h5A;
    alu      = 8'h00;
    pchs     = 8'h00;
    #1;
    check("reset_async", abh, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", abh, 8'h00);

    @(negedge clk);
    reset  = 1'b1;
    data_i = 8'h12;
    alu    = 8'h34;
    pchs   = 8'h56;
    #1;
    check_mux("data", 8'h12, 8'h12, 8'h12);
    check("abh_before_load", abh, 8'h00);
    @(posedge clk);
    #1;
    check("abh_load_data", abh, 8'h12);

    @(negedge clk);
    adh_sel = 3'd1;
    #1;
    check_mux("alu", 8'h34, 8'h34, 8'h34);

    @(negedge clk);
    adh_sel = 3'd2;
    #1;
    check_mux("pchs", 8'h00, 8'h56, 8'h56);
    @(posedge clk);
    #1;
    check("abh_load_pchs", abh, 8'h56);

    @(negedge clk);
    load_abh = 1'b0;
    pchs     = 8'h99;
    #1;
    check("adh_abh_pchs99", adh_abh, 8'h99);
    @(posedge clk);
    #1;
    check("abh_hold", abh, 8'h56);

    @(negedge clk);
    adh_sel = 3'd3;
    #1;
    check_mux("zero", 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    adh_sel = 3'd4;
    #1;
    check_mux("one", 8'h01, 8'h01, 8'h01);

    @(negedge clk);
    adh_sel = 3'd6;
    #1;
    check_mux("rsv6", 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    adh_sel = 3'd7;
    #1;
    check_mux("rsv7", 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check("abh_hold_rsv", abh, 8'h56);

    @(negedge clk);
    adh_sel  = 3'd5;
    load_abh = 1'b1;
    #1;
    check_mux("ff", 8'hFF, 8'hFF, 8'hFF);
    @(posedge clk);
    #1;
    check("abh_load_ff", abh, 8'hFF);

    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abh_async_reset", abh, 8'h00);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abh_reload_ff", abh, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adh_bus_unit.md
Name: adh_bus_unit

Overview:
- Address-high (ADH) bus steering block of the 6502 core datapath.
- Combinationally drives three ADH views from one 3-bit select:
  - adh_pchs: feeds the PC-high select logic.
  - adh_sb: feeds the secondary bus and ABH.
  - adh_abh: feeds the address-bus-high register.
- Holds the address-bus-high register (abh), whose value drives address[15:8].

Parameters:
- none (widths fixed at 8 bits; the select is 3 bits)

Ports:
- clk  input  1  core clock; abh register updates on the rising edge
- reset  input  1  asynchronous, active-low reset; clears abh
- adh_sel  input  3  ADH source select (microcode field)
- load_abh  input  1  abh load enable
- data_i  input  8  external data bus input
- alu  input  8  ALU result
- pchs  input  8  selected next-PC high byte
- adh_pchs  output  8  ADH view feeding the PCHS mux (combinational)
- adh_sb  output  8  ADH view feeding SB and ABH (combinational)
- adh_abh  output  8  value presented to the abh register (combinational)
- abh  output  8  registered address high byte

Behaviour:
- Select encodings (shared package constants):
  - ADH_DATA=0
  - ADH_ALU=1
  - ADH_PCHS=2
  - ADH_ZERO=3
  - ADH_ONE=4
  - ADH_FF=5
  - 6 and 7 are reserved.
- adh_pchs, per select:
  - DATA: data_i
  - ALU: alu
  - ZERO: 0x00
  - ONE: 0x01
  - FF: 0xFF
  - PCHS: 0x00. pchs is never routed to adh_pchs, because pchs is derived from adh_pchs and this would form a combinational loop.
  - reserved: 0x00
- adh_sb, per select:
  - DATA: data_i
  - ALU: alu
  - PCHS: pchs
  - ZERO: 0x00
  - ONE: 0x01 (stack page)
  - FF: 0xFF (vector page)
  - reserved: 0x00
- adh_abh: equals pchs when adh_sel==ADH_PCHS; otherwise equals adh_sb.
- All three mux outputs are purely combinational.
  - Zero latency.
  - No latches.
  - Fully specified for all 8 select codes.
- abh register:
  - reset low: abh=0x00 immediately, independent of clk.
  - reset high, rising clk edge with load_abh=1: abh<=adh_abh.
  - reset high, load_abh=0: abh holds its value.
  - Reset deassertion takes effect at the next edge. The register loads on the first edge with load_abh=1 after reset is released.
  - Reset asserted mid-operation overrides load_abh.
- No handshake. Ready gating is folded into load_abh by the caller.
- Inputs changing in the same cycle as a load: the value sampled is whatever adh_abh is at the edge.

Decomposition:
- Shared package cpu6502_pkg holds:
  - the ADH_* select constants;
  - the constants ADH_CONST_ZERO=8'h00, ADH_CONST_ONE=8'h01 and ADH_CONST_FF=8'h FF.
- One natural sub-module, adh_source_mux: the combinational 8-way selector producing adh_pchs and adh_sb.
- The adh_abh override and the abh register stay in the top level of adh_bus_unit.

Test Plan:
- Reset: hold reset=0, set load_abh=1, adh_sel=DATA, data_i=0x5A, and toggle clk -> abh stays 0x00.
- Release reset: set adh_sel=DATA, data_i=0x12, alu=0x34, pchs=0x56 -> adh_pchs=0x12, adh_sb=0x12, adh_abh=0x12. On the next clk edge with load_abh=1, abh=0x12.
- ALU path, adh_sel=ALU -> adh_pchs=0x34, adh_sb=0x34, adh_abh=0x34.
- PCHS path, adh_sel=PCHS -> adh_pchs=0x00, adh_sb=0x56, adh_abh=0x56. After an edge with load_abh=1, abh=0x56. After a further edge with load_abh=0 and pchs=0x99, abh remains 0x56.
- Constant selects:
  - ZERO: all three outputs = 0x00.
  - ONE: all three outputs = 0x01.
  - FF: all three outputs = 0xFF.
  - codes 6 and 7: adh_pchs=0x00, adh_sb=0x00, adh_abh=0x00.
- Asynchronous reset mid-run: with abh=0xFF, pulse reset low between clock edges -> abh=0x00 immediately.
